// File: rtl/spi_boot_loader.sv
// spi_boot_loader
//   Streams (address, word) write requests into the PULPino SPI slave as
//   72-bit mode-0 write frames {WR_CMD, addr, data}, MSB first. On a boot-done
//   request it releases the core by raising fetch_enable_o, which stays high
//   until reset.
//
// Ports
//   clk, rst_n             system clock, asynchronous active-low reset
//   wr_valid_i/wr_ready_o  write request handshake
//   wr_addr_i, wr_data_i   request payload, sampled on the handshake cycle
//   boot_done_i            level or pulse requesting core start
//   spi_clk_o, spi_cs_o,   SPI slave pins (cs active-low)
//   spi_sdo0_o
//   fetch_enable_o         core fetch enable (sticky)
//   busy_o                 frame in progress (shift, hold or gap)
//   words_sent_o           completed frame count, wraps at 16 bits
module spi_boot_loader #(
  parameter int unsigned CLK_DIV = 4,
  parameter logic [7:0]  WR_CMD  = 8'h02
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid_i,
  output logic        wr_ready_o,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic        boot_done_i,
  output logic        spi_clk_o,
  output logic        spi_cs_o,
  output logic        spi_sdo0_o,
  output logic        fetch_enable_o,
  output logic        busy_o,
  output logic [15:0] words_sent_o
);

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_HOLD, S_GAP, S_RUN} state_t;

  localparam logic [8:0] DIV_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LAST = 9'(2 * CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [71:0] shreg_q, shreg_d;
  logic [6:0]  bit_q, bit_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        phase_q, phase_d;   // 0: SPI clock low phase, 1: high phase
  logic        pend_q, pend_d;
  logic [15:0] words_q, words_d;
  logic        cs_q, cs_d;
  logic        sclk_q, sclk_d;
  logic        sdo_q, sdo_d;
  logic        ready_q, ready_d;
  logic        fetch_q, fetch_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    words_d = words_q;
    // A boot request seen in any state is remembered; it only matters once
    // the machine is back in IDLE.
    pend_d  = pend_q | boot_done_i;

    case (state_q)
      S_IDLE: begin
        if (wr_valid_i && ready_q) begin
          shreg_d = {WR_CMD, wr_addr_i, wr_data_i};
          bit_d   = 7'd71;
          cnt_d   = '0;
          phase_d = 1'b0;
          state_d = S_SHIFT;
        end else if (boot_done_i || pend_q) begin
          state_d = S_RUN;
        end
      end
      S_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (bit_q == 7'd0) begin
              state_d = S_HOLD;
            end else begin
              bit_d   = bit_q - 7'd1;
              shreg_d = {shreg_q[70:0], 1'b0};
            end
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          words_d = words_q + 16'd1;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      default: state_d = S_RUN;
    endcase

    // Outputs are registered images of the next state so every pin changes
    // on the same edge as the state it belongs to.
    cs_d    = !(state_d == S_SHIFT || state_d == S_HOLD);
    sclk_d  = (state_d == S_SHIFT) && phase_d;
    busy_d  = (state_d == S_SHIFT) || (state_d == S_HOLD) || (state_d == S_GAP);
    // With a boot pending, IDLE only passes through to RUN, so no further
    // write may be offered.
    ready_d = (state_d == S_IDLE) && !pend_d;
    fetch_d = fetch_q | (state_d == S_RUN);
    case (state_d)
      S_SHIFT: sdo_d = shreg_d[71];
      S_HOLD:  sdo_d = sdo_q;
      default: sdo_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      pend_q  <= 1'b0;
      words_q <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
      ready_q <= 1'b0;
      fetch_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      pend_q  <= pend_d;
      words_q <= words_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      sdo_q   <= sdo_d;
      ready_q <= ready_d;
      fetch_q <= fetch_d;
      busy_q  <= busy_d;
    end
  end

  // Frame payload carries no reset; it is always loaded before use.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign wr_ready_o     = ready_q;
  assign spi_clk_o      = sclk_q;
  assign spi_cs_o       = cs_q;
  assign spi_sdo0_o     = sdo_q;
  assign fetch_enable_o = fetch_q;
  assign busy_o         = busy_q;
  assign words_sent_o   = words_q;

endmodule
